// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR port arbiter.
// Holds the arbiter FSM state encoding, the arbitration-mode constants and a
// helper that sizes port-index fields.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_ACK     = 2'd2,
        ST_REFRESH = 2'd3
    } arb_state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width needed to hold a port index (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// Read-tag FIFO: remembers which port issued each outstanding read so the
// returning data can be steered back to it.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   push, push_data : enqueue a tag (ignored when full)
//   pop         : dequeue the head tag (ignored when empty)
//   head        : tag at the head of the queue
//   full, empty : occupancy flags
module ddr_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Multi-port arbiter in front of a single DDR controller port.
// One request is in flight at a time: IDLE picks a winner and registers its
// fields onto dn_*, ISSUE holds dn_req until dn_ack, ACK pulses ack[winner],
// REFRESH blocks new grants while refresh_strobe is high. Reads leave a tag in
// a FIFO so returning data can be routed back with rd_valid[port].
// Ports:
//   CLK, RST              : clock, async active-low reset
//   refresh_strobe        : refresh pending, blocks new grants
//   req/lock/we           : per-port request, burst lock, write enable
//   we_array/addr/wdata   : per-port byte enables, address, write data (packed)
//   ack, rd_valid, rdata  : grant-complete pulse, read-valid pulse, read data
//   dn_*                  : downstream request channel and read return
//   rd_underflow          : sticky flag, read data returned with no tag
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 32,
    parameter int MODE      = 1,
    parameter int MAX_BURST = 8,
    parameter int RD_DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       refresh_strobe,
    input  logic [NPORTS-1:0]          req,
    input  logic [NPORTS-1:0]          lock,
    input  logic [NPORTS-1:0]          we,
    input  logic [NPORTS*(DATA_W/8)-1:0] we_array,
    input  logic [NPORTS*ADDR_W-1:0]   addr,
    input  logic [NPORTS*DATA_W-1:0]   wdata,
    output logic [NPORTS-1:0]          ack,
    output logic [NPORTS-1:0]          rd_valid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       dn_req,
    input  logic                       dn_ack,
    output logic                       dn_we,
    output logic [DATA_W/8-1:0]        dn_we_array,
    output logic [ADDR_W-1:0]          dn_address,
    output logic [DATA_W-1:0]          dn_wdata,
    input  logic                       dn_rd_valid,
    input  logic [DATA_W-1:0]          dn_rdata,
    output logic                       rd_underflow
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = idx_width(NPORTS);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    arb_state_e        state_r;
    arb_state_e        state_next_s;
    logic [IDX_W-1:0]  winner_r;
    logic [IDX_W-1:0]  last_winner_r;
    logic [IDX_W-1:0]  arb_win_s;
    logic [IDX_W-1:0]  scan_idx_s;
    logic              arb_found_s;
    logic              lock_path_s;
    logic [NPORTS-1:0] elig_s;
    logic [BC_W-1:0]   burst_cnt_r;
    logic              lock_active_r;
    logic              grant_s;
    logic              accept_s;
    logic              dn_req_r;
    logic              dn_we_r;
    logic [BE_W-1:0]   dn_be_r;
    logic [ADDR_W-1:0] dn_addr_r;
    logic [DATA_W-1:0] dn_wdata_r;
    logic [NPORTS-1:0] ack_r;
    logic              underflow_r;
    logic              push_s;
    logic              pop_s;
    logic [IDX_W-1:0]  head_s;
    logic              full_s;
    logic              empty_s;

    // A read may only be granted while its tag has somewhere to go; writes never wait on the FIFO.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NPORTS; i++) begin
            elig_s[i] = req[i] & (we[i] | ~full_s);
        end
    end

    // Winner selection: a locked port that still requests takes absolute priority,
    // otherwise scan from port 0 (fixed) or from last_winner+1 (round-robin).
    always_comb begin
        arb_found_s = 1'b0;
        arb_win_s   = '0;
        scan_idx_s  = '0;
        lock_path_s = lock_active_r & req[last_winner_r];
        if (lock_path_s) begin
            arb_found_s = elig_s[last_winner_r];
            arb_win_s   = last_winner_r;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                scan_idx_s  = (MODE == MODE_FIXED) ? IDX_W'(i)
                                                   : IDX_W'((int'(last_winner_r) + 1 + i) % NPORTS);
                arb_win_s   = (!arb_found_s && elig_s[scan_idx_s]) ? scan_idx_s : arb_win_s;
                arb_found_s = arb_found_s | elig_s[scan_idx_s];
            end
        end
    end

    assign grant_s  = (state_r == ST_IDLE) & ~refresh_strobe & arb_found_s;
    assign accept_s = (state_r == ST_ISSUE) & dn_ack;

    // Next-state logic; refresh is only honoured from IDLE so an issued request always finishes.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (refresh_strobe) begin
                    state_next_s = ST_REFRESH;
                end else if (arb_found_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (dn_ack) begin
                    state_next_s = ST_ACK;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_ACK: state_next_s = ST_IDLE;
            ST_REFRESH: begin
                if (!refresh_strobe) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REFRESH;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant capture, downstream handshake, ack pulse, burst-lock tracking and underflow flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            winner_r      <= '0;
            last_winner_r <= IDX_W'(NPORTS - 1);
            dn_req_r      <= 1'b0;
            dn_we_r       <= 1'b0;
            dn_be_r       <= '0;
            dn_addr_r     <= '0;
            dn_wdata_r    <= '0;
            ack_r         <= '0;
            burst_cnt_r   <= '0;
            lock_active_r <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            ack_r <= '0;
            if (grant_s) begin
                winner_r      <= arb_win_s;
                last_winner_r <= arb_win_s;
                dn_req_r      <= 1'b1;
                dn_we_r       <= we[arb_win_s];
                dn_be_r       <= we_array[int'(arb_win_s)*BE_W +: BE_W];
                dn_addr_r     <= addr[int'(arb_win_s)*ADDR_W +: ADDR_W];
                dn_wdata_r    <= wdata[int'(arb_win_s)*DATA_W +: DATA_W];
            end
            if (accept_s) begin
                dn_req_r <= 1'b0;
                ack_r    <= {{(NPORTS-1){1'b0}}, 1'b1} << winner_r;
            end
            // Lock lapses once the locked port stops requesting (or was never locked).
            if ((state_r == ST_IDLE) && !refresh_strobe && !lock_path_s) begin
                lock_active_r <= 1'b0;
                burst_cnt_r   <= '0;
            end
            if (state_r == ST_ACK) begin
                if (lock[winner_r] && (burst_cnt_r < BC_W'(MAX_BURST - 1))) begin
                    lock_active_r <= 1'b1;
                    burst_cnt_r   <= burst_cnt_r + BC_W'(1);
                end else begin
                    lock_active_r <= 1'b0;
                    burst_cnt_r   <= '0;
                end
            end
            if (dn_rd_valid && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign push_s = accept_s & ~dn_we_r;
    assign pop_s  = dn_rd_valid & ~empty_s;

    ddr_tag_fifo #(
        .W     (IDX_W),
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (push_s),
        .push_data (winner_r),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Read return is steered straight through in the cycle it arrives.
    assign rd_valid     = pop_s ? ({{(NPORTS-1){1'b0}}, 1'b1} << head_s) : '0;
    assign rdata        = dn_rdata;
    assign ack          = ack_r;
    assign dn_req       = dn_req_r;
    assign dn_we        = dn_we_r;
    assign dn_we_array  = dn_be_r;
    assign dn_address   = dn_addr_r;
    assign dn_wdata     = dn_wdata_r;
    assign rd_underflow = underflow_r;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: one round-robin and one fixed-priority
// instance share stimulus; the monitor checks whichever one is selected.
module tb_ddr_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct packed {
        logic [1:0]    port;
        logic          wr;
        logic [BW-1:0] be;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } grant_t;

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] d;
    } read_t;

    localparam logic [AW-1:0] ADDR_TAB [NP] = '{26'h000_0010, 26'h123_4560, 26'h2AB_CDE0, 26'h3FF_FFF0};
    localparam logic [DW-1:0] DATA_TAB [NP] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    localparam logic [BW-1:0] BE_TAB   [NP] = '{4'hF, 4'h3, 4'hC, 4'h5};

    logic clk = 1'b0;
    logic rst_n;
    logic refresh_strobe;
    logic [NP-1:0] req, lock, we;
    logic [NP*BW-1:0] we_array;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic dn_ack, dn_rd_valid;
    logic [DW-1:0] dn_rdata;

    logic [NP-1:0] rr_ack, rr_rd_valid, fx_ack, fx_rd_valid;
    logic [DW-1:0] rr_rdata, fx_rdata, rr_dn_wdata, fx_dn_wdata;
    logic rr_dn_req, fx_dn_req, rr_dn_we, fx_dn_we, rr_unf, fx_unf;
    logic [BW-1:0] rr_dn_be, fx_dn_be;
    logic [AW-1:0] rr_dn_addr, fx_dn_addr;

    logic sel_fix = 1'b0;
    logic [NP-1:0] m_ack, m_rd_valid;
    logic [DW-1:0] m_rdata, m_dn_wdata;
    logic m_dn_req, m_dn_we, m_unf;
    logic [BW-1:0] m_dn_be;
    logic [AW-1:0] m_dn_addr;

    assign m_ack      = sel_fix ? fx_ack      : rr_ack;
    assign m_rd_valid = sel_fix ? fx_rd_valid : rr_rd_valid;
    assign m_rdata    = sel_fix ? fx_rdata    : rr_rdata;
    assign m_dn_req   = sel_fix ? fx_dn_req   : rr_dn_req;
    assign m_dn_we    = sel_fix ? fx_dn_we    : rr_dn_we;
    assign m_dn_be    = sel_fix ? fx_dn_be    : rr_dn_be;
    assign m_dn_addr  = sel_fix ? fx_dn_addr  : rr_dn_addr;
    assign m_dn_wdata = sel_fix ? fx_dn_wdata : rr_dn_wdata;
    assign m_unf      = sel_fix ? fx_unf      : rr_unf;

    always #5 clk = ~clk;

    ddr_port_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MODE(1), .MAX_BURST(8), .RD_DEPTH(4)) u_rr (
        .CLK(clk), .RST(rst_n), .refresh_strobe(refresh_strobe), .req(req), .lock(lock), .we(we),
        .we_array(we_array), .addr(addr), .wdata(wdata), .ack(rr_ack), .rd_valid(rr_rd_valid),
        .rdata(rr_rdata), .dn_req(rr_dn_req), .dn_ack(dn_ack), .dn_we(rr_dn_we), .dn_we_array(rr_dn_be),
        .dn_address(rr_dn_addr), .dn_wdata(rr_dn_wdata), .dn_rd_valid(dn_rd_valid), .dn_rdata(dn_rdata),
        .rd_underflow(rr_unf));

    ddr_port_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MODE(0), .MAX_BURST(8), .RD_DEPTH(4)) u_fx (
        .CLK(clk), .RST(rst_n), .refresh_strobe(refresh_strobe), .req(req), .lock(lock), .we(we),
        .we_array(we_array), .addr(addr), .wdata(wdata), .ack(fx_ack), .rd_valid(fx_rd_valid),
        .rdata(fx_rdata), .dn_req(fx_dn_req), .dn_ack(dn_ack), .dn_we(fx_dn_we), .dn_we_array(fx_dn_be),
        .dn_address(fx_dn_addr), .dn_wdata(fx_dn_wdata), .dn_rd_valid(dn_rd_valid), .dn_rdata(dn_rdata),
        .rd_underflow(fx_unf));

    grant_t gq[$];
    read_t  rq[$];
    int errors = 0;
    int checks = 0;
    int ack_seen = 0;
    int cyc = 0;
    int last_ack_cyc = -1;
    logic chk_space = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic expect_grant(input int p);
        grant_t g;
        g.port = 2'(p);
        g.wr   = we[p];
        g.be   = BE_TAB[p];
        g.a    = ADDR_TAB[p];
        g.d    = DATA_TAB[p];
        gq.push_back(g);
    endtask

    task automatic expect_read(input int p, input logic [DW-1:0] d);
        read_t r;
        r.port = 2'(p);
        r.d    = d;
        rq.push_back(r);
    endtask

    // Pops an expectation for every ack / rd_valid pulse the selected DUT shows.
    task automatic monitor();
        grant_t g;
        read_t  r;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_ack != '0) begin
                checks++;
                ack_seen++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: got ack=%b, required no ack", m_ack);
                end else begin
                    g = gq.pop_front();
                    if (m_ack !== (4'b0001 << g.port) || m_dn_addr !== g.a || m_dn_we !== g.wr ||
                        m_dn_be !== g.be || (g.wr && m_dn_wdata !== g.d)) begin
                        errors++;
                        $display("FAIL grant: got ack=%b we=%b be=%h addr=%h wdata=%h, required ack=%b we=%b be=%h addr=%h wdata=%h",
                                 m_ack, m_dn_we, m_dn_be, m_dn_addr, m_dn_wdata,
                                 4'b0001 << g.port, g.wr, g.be, g.a, g.d);
                    end
                end
                if (chk_space && last_ack_cyc >= 0) begin
                    checks++;
                    if (cyc - last_ack_cyc != 3) begin
                        errors++;
                        $display("FAIL ack_spacing: got %0d cycles, required 3", cyc - last_ack_cyc);
                    end
                end
                last_ack_cyc = cyc;
            end
            if (m_rd_valid != '0) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got rd_valid=%b, required none", m_rd_valid);
                end else begin
                    r = rq.pop_front();
                    if (m_rd_valid !== (4'b0001 << r.port) || m_rdata !== r.d) begin
                        errors++;
                        $display("FAIL read: got rd_valid=%b rdata=%h, required rd_valid=%b rdata=%h",
                                 m_rd_valid, m_rdata, 4'b0001 << r.port, r.d);
                    end
                end
            end
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target);
        int k;
        k = 0;
        while (ack_seen < target && k < 200) begin
            step();
            k++;
        end
        check("ack_count_reached", 64'(ack_seen >= target), 64'd1);
    endtask

    task automatic wait_dn_req();
        int k;
        k = 0;
        while (m_dn_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("dn_req_seen", 64'(m_dn_req), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; lock = '0; refresh_strobe = 1'b0;
        dn_ack = 1'b0; dn_rd_valid = 1'b0; dn_rdata = '0;
        step(3);
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_all();
        int base;
        for (int p = 0; p < NP; p++) begin
            addr[p*AW +: AW]     = ADDR_TAB[p];
            wdata[p*DW +: DW]    = DATA_TAB[p];
            we_array[p*BW +: BW] = BE_TAB[p];
        end
        we = '1;
        rst_n = 1'b0;
        req = '0; lock = '0; refresh_strobe = 1'b0;
        dn_ack = 1'b0; dn_rd_valid = 1'b0; dn_rdata = '0;
        step(2);
        check("rst_dn_req", 64'(rr_dn_req), 64'd0);
        check("rst_ack", 64'(rr_ack), 64'd0);
        check("rst_rd_valid", 64'(rr_rd_valid), 64'd0);
        check("rst_underflow", 64'(rr_unf), 64'd0);
        check("rst_dn_address", 64'(rr_dn_addr), 64'd0);
        check("rst_fx_dn_req", 64'(fx_dn_req), 64'd0);
        rst_n = 1'b1;
        step();

        // Round-robin, all ports writing, dn_ack tied high.
        sel_fix = 1'b0; chk_space = 1'b1; last_ack_cyc = -1; dn_ack = 1'b1;
        base = ack_seen;
        expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
        req = 4'b1111;
        step();
        check("latency_dn_req", 64'(m_dn_req), 64'd1);
        step();
        check("latency_ack", 64'(m_ack), 64'b0001);
        wait_acks(base + 5);
        req = '0; chk_space = 1'b0;
        step(4);
        check("rr_drained", 64'(gq.size()), 64'd0);

        // Fixed priority: port 1 always beats port 3.
        do_reset();
        sel_fix = 1'b1; dn_ack = 1'b1;
        base = ack_seen;
        for (int k = 0; k < 4; k++) expect_grant(1);
        req = 4'b1010;
        wait_acks(base + 4);
        req = '0;
        step(4);
        check("fixed_drained", 64'(gq.size()), 64'd0);

        // Burst lock on port 2: eight grants, then port 0.
        do_reset();
        sel_fix = 1'b0; dn_ack = 1'b1;
        base = ack_seen;
        for (int k = 0; k < 8; k++) expect_grant(2);
        expect_grant(0);
        lock = 4'b0100; req = 4'b0100;
        wait_acks(base + 1);
        req = 4'b0101;
        wait_acks(base + 9);
        req = '0; lock = '0;
        step(4);
        check("lock_drained", 64'(gq.size()), 64'd0);

        // Tag FIFO full blocks reads only.
        do_reset();
        dn_ack = 1'b1; we = 4'b1000;
        base = ack_seen;
        for (int k = 0; k < 4; k++) expect_grant(1);
        req = 4'b0010;
        wait_acks(base + 4);
        step(6);
        check("fifo_full_blocks_read", 64'(ack_seen - base), 64'd4);
        check("fifo_full_no_dn_req", 64'(m_dn_req), 64'd0);
        expect_grant(3);
        req = 4'b1010;
        wait_acks(base + 5);
        req = 4'b0010;
        expect_read(1, 32'hCAFE_0001);
        expect_grant(1);
        dn_rdata = 32'hCAFE_0001; dn_rd_valid = 1'b1;
        step();
        dn_rd_valid = 1'b0;
        wait_acks(base + 6);
        req = '0;
        step(3);
        for (int k = 0; k < 4; k++) expect_read(1, 32'hCAFE_0010 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            dn_rdata = 32'hCAFE_0010 + 32'(k); dn_rd_valid = 1'b1;
            step();
        end
        dn_rd_valid = 1'b0;
        step(2);
        check("fifo_no_underflow", 64'(m_unf), 64'd0);
        check("fifo_reads_drained", 64'(rq.size()), 64'd0);
        check("fifo_grants_drained", 64'(gq.size()), 64'd0);
        we = '1;

        // Refresh raised while a request is in ISSUE.
        do_reset();
        base = ack_seen;
        req = 4'b0001;
        wait_dn_req();
        refresh_strobe = 1'b1;
        step(2);
        check("refresh_issue_held", 64'(m_dn_req), 64'd1);
        expect_grant(0);
        dn_ack = 1'b1;
        wait_acks(base + 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("refresh_no_dn_req", 64'(m_dn_req), 64'd0);
        end
        check("refresh_no_extra_ack", 64'(ack_seen - base), 64'd1);
        expect_grant(0);
        refresh_strobe = 1'b0;
        wait_acks(base + 2);
        req = '0;
        step(4);
        check("refresh_drained", 64'(gq.size()), 64'd0);

        // Underflow and reset mid-ISSUE.
        do_reset();
        check("unf_clear", 64'(m_unf), 64'd0);
        dn_rdata = 32'hDEAD_BEEF; dn_rd_valid = 1'b1;
        #1;
        check("unf_no_rd_valid", 64'(m_rd_valid), 64'd0);
        step();
        dn_rd_valid = 1'b0;
        check("unf_set", 64'(m_unf), 64'd1);
        step(3);
        check("unf_sticky", 64'(m_unf), 64'd1);
        dn_ack = 1'b0;
        req = 4'b0100;
        wait_dn_req();
        base = ack_seen;
        rst_n = 1'b0;
        #1;
        check("rst_abort_dn_req", 64'(m_dn_req), 64'd0);
        check("rst_abort_ack", 64'(m_ack), 64'd0);
        req = '0;
        step(2);
        rst_n = 1'b1;
        dn_ack = 1'b1;
        step(5);
        check("rst_abort_unf_cleared", 64'(m_unf), 64'd0);
        check("rst_abort_no_ack", 64'(ack_seen - base), 64'd0);
        check("final_queues_empty", 64'(gq.size() + rq.size()), 64'd0);
    endtask

    initial begin
        fork
            monitor();
            run_all();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
